// File: rtl/seg_pkg.sv
// Shared constants, types and the hex-to-segment lookup for the 7-segment display driver.
// Segment vectors are active-low, bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [6:0] hex_to_seg_f(input logic [3:0] nibble);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (nibble)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg_f(nibble);

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-shadowed value updates and
// optional leading-zero blanking. All display outputs are registered.
module display_scan
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          boundary;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic          lead_zero;
    logic          blank;

    assign tick     = (pcnt_q == PCNT_MAX);
    assign boundary = tick && (idx_q == 2'd3);

    hex_to_seg u_hex_to_seg (
        .nibble (nib),
        .seg    (seg_dec)
    );

    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_en : pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        // A load coinciding with the frame wrap bypasses pending so it is not lost for a frame.
        if (boundary) begin
            act_val_d = load ? value : pend_val_q;
            act_dp_d  = load ? dp_en : pend_dp_q;
        end
    end

    always_comb begin
        nib       = act_val_q[{idx_q, 2'b00} +: 4];
        lead_zero = 1'b0;
        unique case (idx_q)
            2'd3:    lead_zero = (act_val_q[15:12] == 4'h0);
            2'd2:    lead_zero = (act_val_q[15:8] == 8'h00);
            2'd1:    lead_zero = (act_val_q[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        blank = blank_lz && lead_zero;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q     <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with PRESCALE=4; edge count k is measured from reset release.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_en = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int k = 0;

    display_scan #(.PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp_en    (dp_en),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Advance to the negedge following edge number target.
    task automatic step_to(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp);
        check({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
        check({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
        check({tag, ".dp"}, {15'h0, dp}, {15'h0, e_dp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three cycles
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_out("rst", 4'hF, 7'h7F, 1'b1);
            check("rst.tick", {15'h0, tick}, 16'h0);
        end
        reset = 1'b0;
        k = 0;

        step_to(1);
        check_out("rel", 4'b1110, 7'b1000000, 1'b1);
        check("tick1", {15'h0, tick}, 16'h0);

        // Full scan: load 12AF lands in active at E16
        step_to(1);
        load = 1'b1; value = 16'h12AF; dp_en = 4'b0100;
        step_to(2);
        load = 1'b0;
        step_to(3);
        check("tick3", {15'h0, tick}, 16'h1);
        step_to(16);
        check_out("pre_wrap", 4'b0111, 7'b1000000, 1'b1);
        step_to(17);
        check_out("scan0", 4'b1110, 7'b0001110, 1'b1);
        step_to(19);
        check("tick19", {15'h0, tick}, 16'h1);
        step_to(20);
        check("tick20", {15'h0, tick}, 16'h0);
        check_out("scan0_end", 4'b1110, 7'b0001110, 1'b1);
        step_to(21);
        check_out("scan1", 4'b1101, 7'b0001000, 1'b1);
        step_to(25);
        check_out("scan2", 4'b1011, 7'b0100100, 1'b0);
        step_to(29);
        check_out("scan3", 4'b0111, 7'b1111001, 1'b1);

        // Shadowing: two loads in one frame, only the last reaches the display at E48
        step_to(33);
        load = 1'b1; value = 16'h1111; dp_en = 4'b0000;
        step_to(34);
        load = 1'b0;
        step_to(35);
        check_out("shadow_old0", 4'b1110, 7'b0001110, 1'b1);
        step_to(39);
        load = 1'b1; value = 16'h2222; dp_en = 4'b0000;
        step_to(40);
        load = 1'b0;
        step_to(41);
        check_out("shadow_old2", 4'b1011, 7'b0100100, 1'b0);
        step_to(45);
        check_out("shadow_old3", 4'b0111, 7'b1111001, 1'b1);
        step_to(49);
        check_out("shadow_new0", 4'b1110, 7'b0100100, 1'b1);
        step_to(53);
        check_out("shadow_new1", 4'b1101, 7'b0100100, 1'b1);
        step_to(61);
        check_out("shadow_new3", 4'b0111, 7'b0100100, 1'b1);

        // Boundary collision: load during the idx==3 tick goes straight to active
        step_to(63);
        check("coll.tick", {15'h0, tick}, 16'h1);
        load = 1'b1; value = 16'h8888; dp_en = 4'b0000;
        step_to(64);
        load = 1'b0;
        check_out("coll_before", 4'b0111, 7'b0100100, 1'b1);
        step_to(65);
        check_out("coll_after", 4'b1110, 7'b0000000, 1'b1);

        // Leading-zero blanking with 0050, then 0000
        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0050; dp_en = 4'b1111;
        step_to(66);
        load = 1'b0;
        step_to(81);
        check_out("blk0", 4'b1110, 7'b1000000, 1'b0);
        load = 1'b1; value = 16'h0000; dp_en = 4'b0000;
        step_to(82);
        load = 1'b0;
        step_to(85);
        check_out("blk1", 4'b1101, 7'b0010010, 1'b0);
        step_to(89);
        check_out("blk2", 4'hF, 7'h7F, 1'b1);
        step_to(91);
        check("blk.tick", {15'h0, tick}, 16'h1);
        step_to(93);
        check_out("blk3", 4'hF, 7'h7F, 1'b1);
        step_to(97);
        check_out("zero0", 4'b1110, 7'b1000000, 1'b1);
        step_to(101);
        check_out("zero1", 4'hF, 7'h7F, 1'b1);
        step_to(105);
        check_out("zero2", 4'hF, 7'h7F, 1'b1);
        step_to(109);
        check_out("zero3", 4'hF, 7'h7F, 1'b1);
        blank_lz = 1'b0;
        step_to(110);
        check_out("unblank3", 4'b0111, 7'b1000000, 1'b1);

        // Reset mid-frame with a load pending and another load in the reset cycle
        step_to(113);
        load = 1'b1; value = 16'h4321; dp_en = 4'b1111;
        step_to(114);
        load = 1'b0;
        step_to(121);
        reset = 1'b1;
        load = 1'b1; value = 16'h9999; dp_en = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check_out("mid_rst", 4'hF, 7'h7F, 1'b1);
        check("mid_rst.tick", {15'h0, tick}, 16'h0);
        reset = 1'b0;
        load = 1'b0;
        k = 0;
        step_to(1);
        check_out("post_rst", 4'b1110, 7'b1000000, 1'b1);
        step_to(17);
        check_out("post_rst0", 4'b1110, 7'b1000000, 1'b1);
        step_to(21);
        check_out("post_rst1", 4'b1101, 7'b1000000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
